// File: rtl/drac_pkg.sv
// Shared core types and sizing constants; holds the SIMD execute-to-writeback
// result record and the default sizing of the SIMD writeback buffer.
package drac_pkg;

    localparam int SIMD_WB_DEPTH        = 4;
    localparam int SIMD_WB_STALL_MARGIN = 2;

    typedef struct packed {
        logic         valid;
        logic [63:0]  pc;
        logic [5:0]   gl_index;
        logic [4:0]   vd;
        logic [5:0]   pvd;
        logic [127:0] vresult;
        logic [1:0]   sew;
        logic         ex_valid;
    } exe_wb_simd_instr_t;

endpackage

// File: rtl/simd_wb_buffer.sv
// In-order result buffer between the SIMD unit and the vector regfile write port.
// Optional SIMD_WB_BYPASS_EN forwards a result straight to the head when the buffer is empty.
module simd_wb_buffer
    import drac_pkg::*;
#(
    parameter int DEPTH        = SIMD_WB_DEPTH,
    parameter int STALL_MARGIN = SIMD_WB_STALL_MARGIN
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     flush_i,
    input  exe_wb_simd_instr_t       instruction_simd_i,
    input  logic                     wb_ready_i,
    output exe_wb_simd_instr_t       instruction_simd_o,
    output logic                     stall_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_W  = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN_W = CW'(STALL_MARGIN);

    exe_wb_simd_instr_t mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic               is_empty;
    logic               is_full;
    logic               bypass_hit;
    logic               push;
    logic               pop;

    assign is_empty = (count == '0);
    assign is_full  = (count == DEPTH_W);

`ifdef SIMD_WB_BYPASS_EN
    assign bypass_hit = is_empty & instruction_simd_i.valid & ~flush_i;
`else
    assign bypass_hit = 1'b0;
`endif

    // A full buffer may still accept when the head leaves in the same cycle.
    assign pop  = ~flush_i & ~is_empty & wb_ready_i;
    assign push = ~flush_i & instruction_simd_i.valid & (~is_full | pop)
                & ~(bypass_hit & wb_ready_i);

    always_comb begin
        instruction_simd_o       = bypass_hit ? instruction_simd_i : mem[rd_ptr];
        instruction_simd_o.valid = ~flush_i & (~is_empty | bypass_hit);
    end

    assign empty_o = is_empty;
    assign full_o  = is_full;
    assign count_o = count;
    assign stall_o = (DEPTH_W - count) <= MARGIN_W;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= instruction_simd_i;
    end

`ifndef SYNTHESIS
    a_no_push_when_full : assert property (
        @(posedge clk_i) disable iff (!rstn_i)
        !(instruction_simd_i.valid && is_full && !pop && !flush_i)
    ) else $error("simd_wb_buffer: result dropped, push while full");
`endif

endmodule

// File: tb/tb_simd_wb_buffer.sv
// Self-checking bench for simd_wb_buffer: vector table, directed corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_simd_wb_buffer;
    import drac_pkg::*;

    localparam int DEPTH  = SIMD_WB_DEPTH;
    localparam int MARGIN = SIMD_WB_STALL_MARGIN;
`ifdef SIMD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk_i = 1'b0;
    logic               rstn_i;
    logic               flush_i;
    exe_wb_simd_instr_t instruction_simd_i;
    logic               wb_ready_i;
    exe_wb_simd_instr_t instruction_simd_o;
    logic               stall_o;
    logic               full_o;
    logic               empty_o;
    logic [2:0]         count_o;

    simd_wb_buffer #(.DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .flush_i            (flush_i),
        .instruction_simd_i (instruction_simd_i),
        .wb_ready_i         (wb_ready_i),
        .instruction_simd_o (instruction_simd_o),
        .stall_o            (stall_o),
        .full_o             (full_o),
        .empty_o            (empty_o),
        .count_o            (count_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    exe_wb_simd_instr_t q[$];
    exe_wb_simd_instr_t drained[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exe_wb_simd_instr_t mk(input logic [5:0] pvd, input logic [127:0] vres);
        exe_wb_simd_instr_t r;
        r.valid    = 1'b1;
        r.pc       = {$urandom, $urandom};
        r.gl_index = 6'($urandom);
        r.vd       = 5'($urandom);
        r.pvd      = pvd;
        r.vresult  = vres;
        r.sew      = 2'($urandom);
        r.ex_valid = 1'($urandom);
        return r;
    endfunction

    task automatic idle_inputs();
        flush_i                  = 1'b0;
        wb_ready_i               = 1'b0;
        instruction_simd_i       = '0;
    endtask

    // One clock: drive inputs, compare against the queue model before the edge, then advance the model.
    task automatic cycle(input bit fl, input bit ps, input exe_wb_simd_instr_t d, input bit rdy);
        int sz;
        bit bp, exp_valid, pop, push_ok;
        exe_wb_simd_instr_t e, a;
        flush_i                  = fl;
        instruction_simd_i       = d;
        instruction_simd_i.valid = ps;
        wb_ready_i               = rdy;
        @(negedge clk_i);
        sz        = q.size();
        bp        = BYP && sz == 0 && ps && !fl;
        exp_valid = !fl && (sz > 0 || bp);
        chk("head_valid", 256'(instruction_simd_o.valid), 256'(exp_valid));
        chk("count", 256'(count_o), 256'(sz));
        chk("full", 256'(full_o), 256'(sz == DEPTH));
        chk("empty", 256'(empty_o), 256'(sz == 0));
        chk("stall", 256'(stall_o), 256'((DEPTH - sz) <= MARGIN));
        if (exp_valid) begin
            e = (sz > 0) ? q[0] : d;
            e.valid = 1'b0;
            a = instruction_simd_o;
            a.valid = 1'b0;
            chk("head_payload", 256'(a), 256'(e));
        end
        if (fl) begin
            q.delete();
        end else if (bp && rdy) begin
            e = d;
            e.valid = 1'b1;
            drained.push_back(e);
        end else begin
            pop     = (sz > 0) && rdy;
            push_ok = ps && (sz < DEPTH || pop);
            if (pop) drained.push_back(q.pop_front());
            if (push_ok) begin
                e = d;
                e.valid = 1'b1;
                q.push_back(e);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        bit         fl;
        bit         ps;
        logic [5:0] pvd;
        bit         rdy;
        int         cnt;
        bit         vld;
        logic [5:0] head;
        bit         stall;
        bit         full;
        bit         empty;
    } vec_t;

    vec_t tbl[15];

    initial begin
        exe_wb_simd_instr_t d;
        int pushed;
        bit rdy;
        exe_wb_simd_instr_t sent[$];

        rstn_i = 1'b0;
        idle_inputs();
        #12;
        chk("rst_valid", 256'(instruction_simd_o.valid), 256'(0));
        chk("rst_count", 256'(count_o), 256'(0));
        chk("rst_empty", 256'(empty_o), 256'(1));
        chk("rst_full",  256'(full_o),  256'(0));
        chk("rst_stall", 256'(stall_o), 256'(0));
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        //          fl ps pvd rdy cnt vld head stall full empty
        tbl[0]  = '{0, 1, 5,  0, 1, 1, 5,  0, 0, 0};
        tbl[1]  = '{0, 1, 6,  0, 2, 1, 5,  1, 0, 0};
        tbl[2]  = '{0, 1, 7,  0, 3, 1, 5,  1, 0, 0};
        tbl[3]  = '{0, 1, 8,  0, 4, 1, 5,  1, 1, 0};
        tbl[4]  = '{0, 1, 9,  1, 4, 1, 6,  1, 1, 0};
        tbl[5]  = '{0, 0, 0,  1, 3, 1, 7,  1, 0, 0};
        tbl[6]  = '{0, 0, 0,  1, 2, 1, 8,  1, 0, 0};
        tbl[7]  = '{0, 0, 0,  1, 1, 1, 9,  0, 0, 0};
        tbl[8]  = '{0, 0, 0,  1, 0, 0, 0,  0, 0, 1};
        tbl[9]  = '{0, 1, 1,  0, 1, 1, 1,  0, 0, 0};
        tbl[10] = '{0, 1, 2,  0, 2, 1, 1,  1, 0, 0};
        tbl[11] = '{0, 1, 3,  0, 3, 1, 1,  1, 0, 0};
        tbl[12] = '{1, 1, 4,  0, 0, 0, 0,  0, 0, 1};
        tbl[13] = '{0, 1, 10, 0, 1, 1, 10, 0, 0, 0};
        tbl[14] = '{0, 0, 0,  1, 0, 0, 0,  0, 0, 1};

        for (int i = 0; i < 15; i++) begin
            flush_i                  = tbl[i].fl;
            instruction_simd_i       = mk(tbl[i].pvd, 128'(i));
            instruction_simd_i.valid = tbl[i].ps;
            wb_ready_i               = tbl[i].rdy;
            @(posedge clk_i);
            #1;
            idle_inputs();
            #1;
            chk($sformatf("vec%0d_count", i), 256'(count_o), 256'(tbl[i].cnt));
            chk($sformatf("vec%0d_valid", i), 256'(instruction_simd_o.valid), 256'(tbl[i].vld));
            chk($sformatf("vec%0d_stall", i), 256'(stall_o), 256'(tbl[i].stall));
            chk($sformatf("vec%0d_full", i),  256'(full_o),  256'(tbl[i].full));
            chk($sformatf("vec%0d_empty", i), 256'(empty_o), 256'(tbl[i].empty));
            if (tbl[i].vld)
                chk($sformatf("vec%0d_head", i), 256'(instruction_simd_o.pvd), 256'(tbl[i].head));
        end
        q.delete();
        @(posedge clk_i);
        #1;

        // Flush cycle itself must hide the head.
        cycle(0, 1, mk(20, 128'h20), 0);
        cycle(0, 1, mk(21, 128'h21), 0);
        cycle(1, 0, '0, 1);
        cycle(0, 0, '0, 0);

        // Empty buffer, single push with ready: latency depends on bypass build.
        cycle(0, 1, mk(30, 128'h30), 1);
        cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 0);

        // Ten entries through the pointers with ready toggling.
        drained.delete();
        pushed = 0;
        rdy = 1'b1;
        for (int c = 0; c < 200 && (pushed < 10 || q.size() > 0); c++) begin
            if (pushed < 10 && (q.size() < DEPTH || rdy)) begin
                d = mk(6'(40 + pushed), {16{8'hA5}} ^ 128'(pushed));
                sent.push_back(d);
                cycle(0, 1, d, rdy);
                pushed++;
            end else begin
                cycle(0, 0, '0, rdy);
            end
            rdy = ~rdy;
        end
        chk("wrap_drained", 256'(drained.size()), 256'(10));
        for (int i = 0; i < 10 && i < drained.size(); i++) begin
            chk($sformatf("wrap_pvd%0d", i), 256'(drained[i].pvd), 256'(sent[i].pvd));
            chk($sformatf("wrap_vres%0d", i), 256'(drained[i].vresult), 256'(sent[i].vresult));
        end

        // Reset mid-operation clears everything immediately.
        cycle(0, 1, mk(50, 128'h50), 0);
        cycle(0, 1, mk(51, 128'h51), 0);
        idle_inputs();
        rstn_i = 1'b0;
        #1;
        chk("midrst_count", 256'(count_o), 256'(0));
        chk("midrst_valid", 256'(instruction_simd_o.valid), 256'(0));
        chk("midrst_empty", 256'(empty_o), 256'(1));
        chk("midrst_stall", 256'(stall_o), 256'(0));
        chk("midrst_full",  256'(full_o),  256'(0));
        q.delete();
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        cycle(0, 1, mk(33, 128'h33), 0);
        cycle(0, 0, '0, 0);

        // Randomized traffic; never pushes into a full buffer that is not draining.
        for (int c = 0; c < 400; c++) begin
            bit fl, ps, r;
            fl = ($urandom_range(0, 15) == 0);
            r  = 1'($urandom);
            ps = 1'($urandom) && (q.size() < DEPTH || r);
            cycle(fl, ps, mk(6'($urandom), {$urandom, $urandom, $urandom, $urandom}), r);
        end

        idle_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
